// File: rtl/key_debounce_pkg.sv
// Shared constants and the counter step rule for the push-button debouncer.
package key_debounce_pkg;

  localparam int CNT_W = 20;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEF_CNT_MAX_1 = 20'd999_999;
  localparam cnt_t DEF_CNT_MAX_2 = 20'd999_998;
  localparam logic LED_RST_VAL   = 1'b1;
  localparam logic KEY_RELEASED  = 1'b1;

  // A released sample restarts the window; a held press saturates instead of wrapping.
  function automatic cnt_t cnt_step(input logic key_s, input cnt_t cnt, input cnt_t cnt_max);
    if (key_s == KEY_RELEASED) begin
      return '0;
    end else if (cnt == cnt_max) begin
      return cnt;
    end else begin
      return cnt + cnt_t'(1);
    end
  endfunction

endpackage

// File: rtl/key_debounce_led_sync.sv
// Two-flop synchronizer for the raw button pin; resets to the released level.
module key_sync_2ff
  import key_debounce_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/key_debounce_led.sv
// Debounces an active-low push-button and toggles the LED once per qualified press.
// Optional build macro KEY_DEBOUNCE_SYNC_EN inserts a 2-flop input synchronizer.
module key_debounce_led
  import key_debounce_pkg::*;
#(
  parameter cnt_t cntMAX_1 = DEF_CNT_MAX_1,
  parameter cnt_t cntMAX_2 = DEF_CNT_MAX_2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic led_out
);

  logic key_s;
  cnt_t cnt_q, cnt_d;
  logic key_flag_q, key_flag_d;
  logic led_q, led_d;

`ifdef KEY_DEBOUNCE_SYNC_EN
  key_sync_2ff u_key_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (key_s)
  );
`else
  assign key_s = key_in;
`endif

  // cntMAX_2 sits below the saturation value, so the flag fires once per low period.
  always_comb begin
    cnt_d      = cnt_step(key_s, cnt_q, cntMAX_1);
    key_flag_d = (key_s != KEY_RELEASED) && (cnt_q == cntMAX_2);
    led_d      = key_flag_q ? ~led_q : led_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      key_flag_q <= 1'b0;
      led_q      <= LED_RST_VAL;
    end else begin
      cnt_q      <= cnt_d;
      key_flag_q <= key_flag_d;
      led_q      <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_key_debounce_led.sv
// Randomized bench for key_debounce_led with a run-length reference model.
module tb_key_debounce_led;

  localparam int CM1 = 24;
  localparam int CM2 = 23;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic key_in = 1'b1;
  logic led_out;

  int n_total = 0;
  int n_pass  = 0;
  int flag_cnt = 0;

  key_debounce_led #(.cntMAX_1(20'd24), .cntMAX_2(20'd23)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .led_out   (led_out)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: length of the current run of low key samples (unbounded).
  int unsigned m_run  = 0;
  logic        m_flag = 1'b0;
  logic        m_led  = 1'b1;
  logic [1:0]  m_sync = 2'b11;
  logic        m_ks;

`ifdef KEY_DEBOUNCE_SYNC_EN
  assign m_ks = m_sync[1];
`else
  assign m_ks = key_in;
`endif

  function automatic int unsigned next_run(input int unsigned r, input logic k);
    return k ? 0 : r + 1;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_run  <= 0;
      m_flag <= 1'b0;
      m_led  <= 1'b1;
      m_sync <= 2'b11;
    end else begin
      m_sync <= {m_sync[0], key_in};
      m_run  <= next_run(m_run, m_ks);
      m_flag <= (next_run(m_run, m_ks) == CM2 + 1);
      if (m_flag) m_led <= ~m_led;
    end
  end

  always @(negedge sys_clk) begin
    check("led_out", {31'd0, led_out}, {31'd0, m_led});
    check("key_flag", {31'd0, dut.key_flag_q}, {31'd0, m_flag});
    check("cnt", {12'd0, dut.cnt_q}, (m_run > CM1) ? CM1 : m_run);
    if (dut.key_flag_q === 1'b1) flag_cnt++;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
      key_in = v;
    end
  endtask

  task automatic drive_rand(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
      key_in = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int fc;
    int lat;
    int led_lat;
    int found;

    #2 sys_rst_n = 1'b0;
    #13;
    check("rst_led", {31'd0, led_out}, 32'd1);
    check("rst_cnt", {12'd0, dut.cnt_q}, 32'd0);
    check("rst_flag", {31'd0, dut.key_flag_q}, 32'd0);
    #7 sys_rst_n = 1'b1;

    drive(1'b1, 200);
    check("idle_led", {31'd0, led_out}, 32'd1);
    check("idle_flags", flag_cnt, 32'd0);

    // Clean press with latency measurement.
    fc = flag_cnt;
    lat = 0;
    led_lat = 0;
    @(posedge sys_clk);
    #2 key_in = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (dut.key_flag_q === 1'b1 && lat == 0) lat = i;
      if (led_out === 1'b0 && led_lat == 0) led_lat = i;
    end
    drive(1'b1, 30);
    check("clean_flag_lat", lat, 24 + SYNC_LAT);
    check("clean_led_lat", led_lat, 25 + SYNC_LAT);
    check("clean_flags", flag_cnt - fc, 32'd1);
    check("clean_led", {31'd0, led_out}, 32'd0);

    // Bouncing presses.
    for (int r = 0; r < 2; r++) begin
      fc = flag_cnt;
      drive_rand(50);
      drive(1'b0, 80);
      drive_rand(50);
      drive(1'b1, 50);
      check("bounce_flags", flag_cnt - fc, 32'd1);
      check("bounce_led", {31'd0, led_out}, (r == 0) ? 32'd1 : 32'd0);
    end

    // Boundary: one sample short, then exactly enough.
    fc = flag_cnt;
    drive(1'b0, 23);
    drive(1'b1, 30);
    check("short_flags", flag_cnt - fc, 32'd0);
    check("short_led", {31'd0, led_out}, 32'd0);
    fc = flag_cnt;
    drive(1'b0, 24);
    drive(1'b1, 30);
    check("exact_flags", flag_cnt - fc, 32'd1);
    check("exact_led", {31'd0, led_out}, 32'd1);

    // Long hold saturates.
    fc = flag_cnt;
    drive(1'b0, 1000);
    @(negedge sys_clk);
    check("hold_cnt", {12'd0, dut.cnt_q}, 32'd24);
    check("hold_flags", flag_cnt - fc, 32'd1);
    check("hold_led", {31'd0, led_out}, 32'd0);
    drive(1'b1, 30);

    // Reset in the middle of a press.
    @(posedge sys_clk);
    #2 key_in = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (dut.cnt_q == 20'd20) begin
        found = 1;
        break;
      end
    end
    check("mid_reach20", found, 32'd1);
    #3 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_led", {31'd0, led_out}, 32'd1);
    check("mid_rst_cnt", {12'd0, dut.cnt_q}, 32'd0);
    check("mid_rst_flag", {31'd0, dut.key_flag_q}, 32'd0);
    #20 sys_rst_n = 1'b1;
    fc = flag_cnt;
    drive(1'b1, 10);
    check("mid_no_flag", flag_cnt - fc, 32'd0);
    drive(1'b0, 24);
    drive(1'b1, 30);
    check("fresh_flags", flag_cnt - fc, 32'd1);
    check("fresh_led", {31'd0, led_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
